alu_control_mc: RTL

Parametrised successor to the single-cycle ALU control decoder. It decodes `alu_op`/`funct7`/`funct3` into a 5-bit ALU control code covering the full RV32I integer ALU set plus the RV32M multiply/divide ops, and flags illegal encodings instead of emitting X. It sequences multi-cycle operations with a latency counter and a valid/ready handshake, so the execute stage can stall on MUL/DIV. It sits between the main control unit and the ALU/MDU datapath.

---
 rtl/alu_ctrl_pkg.sv | 54 +++++
 rtl/alu_ctrl_decode.sv | 60 ++++++
 rtl/alu_control_mc.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, op-class constants and FSM state encodings
// for the multi-cycle ALU control decoder.
package alu_ctrl_pkg;

    localparam int ALU_CTRL_W = 5;
    typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_AND    = 5'b00000;
    localparam alu_ctrl_t ALU_OR     = 5'b00001;
    localparam alu_ctrl_t ALU_ADD    = 5'b00010;
    localparam alu_ctrl_t ALU_XOR    = 5'b00011;
    localparam alu_ctrl_t ALU_SLL    = 5'b00100;
    localparam alu_ctrl_t ALU_SRL    = 5'b00101;
    localparam alu_ctrl_t ALU_SUB    = 5'b00110;
    localparam alu_ctrl_t ALU_SRA    = 5'b00111;
    localparam alu_ctrl_t ALU_SLT    = 5'b01000;
    localparam alu_ctrl_t ALU_SLTU   = 5'b01001;
    localparam alu_ctrl_t ALU_MUL    = 5'b10000;
    localparam alu_ctrl_t ALU_MULH   = 5'b10001;
    localparam alu_ctrl_t ALU_MULHSU = 5'b10010;
    localparam alu_ctrl_t ALU_MULHU  = 5'b10011;
    localparam alu_ctrl_t ALU_DIV    = 5'b10100;
    localparam alu_ctrl_t ALU_DIVU   = 5'b10101;
    localparam alu_ctrl_t ALU_REM    = 5'b10110;
    localparam alu_ctrl_t ALU_REMU   = 5'b10111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic alu_ctrl_t base_code(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purpose: combinational decode of alu_op/funct7/funct3 into an ALU control code.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [1:0] alu_op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output alu_ctrl_t  code,
    output logic       illegal,
    output logic       multicycle
);

    // Illegal paths leave code at ADD so the datapath never sees X.
    always_comb begin
        code       = ALU_ADD;
        illegal    = 1'b0;
        multicycle = 1'b0;
        case (alu_op)
            ALU_OP_ADD: code = ALU_ADD;
            ALU_OP_SUB: code = ALU_SUB;
            ALU_OP_RTYPE: begin
                case (funct7)
                    F7_BASE: code = base_code(funct3);
                    F7_ALT: begin
                        if (funct3 == 3'b000)      code = ALU_SUB;
                        else if (funct3 == 3'b101) code = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M) begin
                            code       = {2'b10, funct3};
                            multicycle = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: begin
                // I-type: funct7 only matters for the shift encodings.
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_BASE) code = ALU_SLL;
                    else                   illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_BASE)     code = ALU_SRL;
                    else if (funct7 == F7_ALT) code = ALU_SRA;
                    else                       illegal = 1'b1;
                end else begin
                    code = base_code(funct3);
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_control_mc.sv
// Purpose: registered ALU control code with MUL/DIV latency sequencing.
// Latency: code valid 1 cycle after accept; done_o at +1 / +MUL_LAT / +DIV_LAT.
// Backpressure: ready_o low while a multi-cycle op runs; flush_i aborts at once.
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 33
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [1:0]            alu_op_i,
    input  logic [6:0]            funct7_i,
    input  logic [2:0]            funct3_i,
    output logic [ALU_CTRL_W-1:0] alu_control_op_o,
    output logic                  op_valid_o,
    output logic                  multicycle_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  illegal_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

    alu_ctrl_t        dec_code;
    logic             dec_illegal;
    logic             dec_mc;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_ctrl_t        code_q;
    logic             illegal_q;
    logic             mc_q;
    logic             accept;
    logic             dec_is_div;
    logic             dec_single;

    alu_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
        .alu_op     (alu_op_i),
        .funct7     (funct7_i),
        .funct3     (funct3_i),
        .code       (dec_code),
        .illegal    (dec_illegal),
        .multicycle (dec_mc)
    );

    assign ready_o    = (state_q != ST_RUN);
    assign accept     = valid_i && ready_o && !flush_i;
    assign dec_is_div = dec_code[2];
    // A one-cycle MUL completes like a base op and never enters RUN.
    assign dec_single = !dec_mc || (!dec_is_div && (MUL_LAT == 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            if (dec_single) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RUN;
                cnt_d   = dec_is_div ? DIV_LOAD : MUL_LOAD;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cnt_q == '0) state_d = ST_DONE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            code_q    <= ALU_ADD;
            illegal_q <= 1'b0;
            mc_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush_i) begin
                illegal_q <= 1'b0;
                mc_q      <= 1'b0;
            end else if (accept) begin
                code_q    <= dec_code;
                illegal_q <= dec_illegal;
                mc_q      <= dec_mc;
            end
        end
    end

    assign alu_control_op_o = code_q;
    assign op_valid_o       = (state_q != ST_IDLE);
    assign busy_o           = (state_q == ST_RUN);
    assign done_o           = (state_q == ST_DONE);
    assign multicycle_o     = mc_q && op_valid_o;
    assign illegal_o        = illegal_q && op_valid_o;

endmodule
